// File: rtl/descriptor_pkg.sv
// descriptor_pkg: shared descriptor layout, walker states and shadow storage
package descriptor_pkg;
  localparam int DESC_WORDS = 8;
  localparam int W_SRC = 0;
  localparam int W_DST = 2;
  localparam int W_NEXT = 4;
  localparam int W_LEN = 6;
  localparam int W_CTRL = 7;
  localparam int OWNED_BIT = 31;
  typedef enum logic [3:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_CHECK, S_PRESENT, S_EXEC, S_WB, S_NEXT, S_FINISH
  } state_t;
  typedef struct packed {
    logic [DESC_WORDS-1:0][31:0] w;
  } desc_t;
endpackage

// File: rtl/descriptor_avalon_port.sv
// descriptor_avalon_port: single-outstanding Avalon-MM read/write handshake
module descriptor_avalon_port #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              cmd_ack,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid
);
  logic pending;
  // a new read is withheld until the previous one has returned its data
  assign m_read = req_rd & ~pending;
  assign m_write = req_wr;
  assign m_address = req_addr;
  assign m_writedata = req_wr ? req_wdata : '0;
  assign m_byteenable = 4'hF;
  assign cmd_ack = (m_read | m_write) & ~m_waitrequest;
  assign rd_valid = pending & m_readdatavalid;
  assign rd_data = m_readdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pending <= 1'b0;
    else pending <= (m_read & ~m_waitrequest) ? 1'b1 : rd_valid ? 1'b0 : pending;
endmodule

// File: rtl/descriptor_fetch_master.sv
// descriptor_fetch_master: walks a linked list of descriptors, hands each to the
// datapath and writes completion status back with the owned bit cleared
module descriptor_fetch_master
  import descriptor_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DESC_WORDS = descriptor_pkg::DESC_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_desc_addr,
  output logic              busy,
  output logic              chain_done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [31:0]       desc_src,
  output logic [31:0]       desc_dst,
  output logic [15:0]       desc_len,
  output logic [7:0]        desc_ctrl,
  input  logic              done_valid,
  input  logic [15:0]       done_bytes,
  input  logic [7:0]        done_status
);
  localparam int IW = $clog2(DESC_WORDS);
  state_t state, state_nx;
  logic [ADDR_W-1:0] cur_ptr, req_addr;
  logic [IW-1:0] idx;
  desc_t desc;
  logic [15:0] bytes_q;
  logic [7:0] status_q;
  logic req_rd, req_wr, cmd_ack, rd_valid;
  logic [31:0] req_wdata, rd_data;
  logic unused;
  assign unused = ^desc;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      cur_ptr <= '0;
      idx <= '0;
      desc <= '0;
      bytes_q <= '0;
      status_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        cur_ptr <= first_desc_addr;
        idx <= '0;
      end
      // idx wraps back to 0 after the last word of each descriptor
      if (state == S_RD_WAIT && rd_valid) begin
        desc.w[idx] <= rd_data;
        idx <= idx + 1'b1;
      end
      if (state == S_EXEC && done_valid) begin
        bytes_q <= done_bytes;
        status_q <= done_status;
      end
      if (state == S_NEXT) begin
        cur_ptr <= {desc.w[W_NEXT][ADDR_W-1:5], 5'd0};
        idx <= '0;
      end
    end
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    state_nx = start ? S_RD_REQ : S_IDLE;
      S_RD_REQ:  state_nx = cmd_ack ? S_RD_WAIT : S_RD_REQ;
      S_RD_WAIT: state_nx = !rd_valid ? S_RD_WAIT : (idx == IW'(DESC_WORDS-1)) ? S_CHECK : S_RD_REQ;
      S_CHECK:   state_nx = desc.w[W_CTRL][OWNED_BIT] ? S_PRESENT : S_FINISH;
      S_PRESENT: state_nx = desc_ready ? S_EXEC : S_PRESENT;
      S_EXEC:    state_nx = done_valid ? S_WB : S_EXEC;
      S_WB:      state_nx = cmd_ack ? S_NEXT : S_WB;
      S_NEXT:    state_nx = S_RD_REQ;
      S_FINISH:  state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end
  assign req_rd = state == S_RD_REQ;
  assign req_wr = state == S_WB;
  assign req_addr = req_wr ? cur_ptr + ADDR_W'(W_CTRL*4) : req_rd ? cur_ptr + ADDR_W'({idx, 2'b00}) : '0;
  assign req_wdata = {desc.w[W_CTRL][31:24] & 8'h7F, status_q, bytes_q};
  assign busy = state != S_IDLE && state != S_FINISH;
  assign chain_done = state == S_FINISH;
  assign desc_valid = state == S_PRESENT;
  assign desc_src = desc.w[W_SRC];
  assign desc_dst = desc.w[W_DST];
  assign desc_len = desc.w[W_LEN][15:0];
  assign desc_ctrl = desc.w[W_CTRL][31:24];
  descriptor_avalon_port #(.ADDR_W(ADDR_W)) u_port (
    .clk(clk),
    .reset_n(reset_n),
    .req_rd(req_rd),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .cmd_ack(cmd_ack),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .m_address(m_address),
    .m_read(m_read),
    .m_write(m_write),
    .m_writedata(m_writedata),
    .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid)
  );
endmodule

// File: tb/tb_descriptor_fetch_master.sv
// tb_descriptor_fetch_master: table of descriptors built into a memory model,
// scoreboard queues of expected reads, descriptors and writebacks
module tb_descriptor_fetch_master;
  logic clk = 1'b0;
  logic reset_n, start, m_read, m_write, m_waitrequest, m_readdatavalid;
  logic busy, chain_done, desc_valid, desc_ready, done_valid;
  logic [11:0] first_desc_addr, m_address;
  logic [31:0] m_writedata, m_readdata, desc_src, desc_dst;
  logic [3:0] m_byteenable;
  logic [15:0] desc_len, done_bytes;
  logic [7:0] desc_ctrl, done_status;
  always #5 clk = ~clk;

  descriptor_fetch_master #(.ADDR_W(12), .DESC_WORDS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .first_desc_addr(first_desc_addr),
    .busy(busy), .chain_done(chain_done), .m_address(m_address), .m_read(m_read),
    .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_src(desc_src), .desc_dst(desc_dst),
    .desc_len(desc_len), .desc_ctrl(desc_ctrl), .done_valid(done_valid),
    .done_bytes(done_bytes), .done_status(done_status)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] src, dst, nxt, len, ctrl;
    logic [15:0] bytes;
    logic [7:0] status;
    logic [31:0] wb;
    bit nowr;
  } rec_t;
  typedef struct {logic [31:0] src, dst; logic [15:0] len; logic [7:0] ctrl;} dexp_t;
  typedef struct {logic [11:0] addr; logic [31:0] data;} wexp_t;

  rec_t tbl[9];
  dexp_t dq[$];
  wexp_t wq[$];
  logic [11:0] rq[$];
  logic [23:0] dpq[$];
  logic [31:0] mem[0:1023];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ctl"}, {busy, chain_done, m_read, m_write, desc_valid, m_address, m_writedata, m_byteenable},
        {5'b0, 12'h0, 32'h0, 4'hF});
    chk({name, "_desc"}, {desc_src, desc_dst, desc_len, desc_ctrl}, 88'h0);
  endtask

  task automatic build(input int first, input int last);
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = first; i <= last; i++) begin
      rec_t r = tbl[i];
      int b = int'(r.addr[11:2]);
      if (!r.nowr) begin
        mem[b] = r.src; mem[b+1] = ~r.src; mem[b+2] = r.dst; mem[b+3] = ~r.dst;
        mem[b+4] = r.nxt; mem[b+5] = 32'h5A5A_0005; mem[b+6] = r.len; mem[b+7] = r.ctrl;
      end
      for (int k = 0; k < 8; k++) rq.push_back(r.addr + 12'(4 * k));
      if (r.ctrl[31]) begin
        dq.push_back('{r.src, r.dst, r.len[15:0], r.ctrl[31:24]});
        wq.push_back('{r.addr + 12'h01C, r.wb});
        dpq.push_back({r.status, r.bytes});
      end
    end
  endtask

  task automatic run_chain(input int first, input int last, input bit stall, input int hold,
                           input int exp_dv, input int exp_cd, input bit abort);
    int cyc = -1, done_cnt = 0, post = 0, hold_cnt = 0, dcnt = 0, rcnt = 0, wr_stalls = 0;
    bit dv_seen = 0, stalled_prev = 0;
    logic [45:0] prev_req = '0;
    logic [87:0] snap = '0;
    logic [31:0] rdata_q = '0;
    logic [23:0] pend_done = '0;
    build(first, last);
    first_desc_addr = tbl[first].addr;
    @(negedge clk);
    start = 1'b1;
    for (int t = 0; t < 3000 && post < 4; t++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      done_valid = 1'b0;
      m_readdatavalid = 1'b0;
      m_readdata = 32'h0;
      if (chain_done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
        if (exp_cd >= 0) chk("done_cycle", cyc, exp_cd);
      end
      if (desc_valid && !dv_seen) begin
        dv_seen = 1;
        if (exp_dv >= 0) chk("first_dv_cycle", cyc, exp_dv);
      end
      if (stalled_prev) chk("req_stable", {m_read, m_write, m_address, m_writedata}, prev_req);
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          m_readdatavalid = 1'b1;
          m_readdata = rdata_q;
        end
      end
      m_waitrequest = stall ? 1'($urandom_range(1)) : (abort && m_write);
      if (abort && m_write) begin
        wr_stalls++;
        if (wr_stalls == 4) begin
          #2 reset_n = 1'b0;
          #1 chk_reset("async_rst");
          return;
        end
      end
      if (m_read && !m_waitrequest) begin
        if (rq.size() == 0) fail("unexpected_read");
        else chk("rd_addr", m_address, rq.pop_front());
        rdata_q = mem[m_address[11:2]];
        rcnt = stall ? $urandom_range(4, 1) : 1;
      end
      if (m_write && !m_waitrequest) begin
        if (wq.size() == 0) fail("unexpected_write");
        else begin
          wexp_t w = wq.pop_front();
          chk("wb_addr", m_address, w.addr);
          chk("wb_data", m_writedata, w.data);
          chk("wb_be", m_byteenable, 4'hF);
        end
        mem[m_address[11:2]] = m_writedata;
      end
      stalled_prev = (m_read || m_write) && m_waitrequest;
      prev_req = {m_read, m_write, m_address, m_writedata};
      desc_ready = 1'b1;
      if (desc_valid && hold_cnt < hold) begin
        desc_ready = 1'b0;
        if (hold_cnt == 0) snap = {desc_src, desc_dst, desc_len, desc_ctrl};
        else chk("desc_held", {desc_src, desc_dst, desc_len, desc_ctrl}, snap);
        chk("bus_idle", {m_read, m_write}, 2'b00);
        if (hold_cnt == 10) begin
          done_valid = 1'b1;
          done_bytes = 16'hDEAD;
          done_status = 8'hEE;
        end
        hold_cnt++;
      end
      if (desc_valid && desc_ready) begin
        if (dq.size() == 0) fail("unexpected_desc");
        else begin
          dexp_t e = dq.pop_front();
          chk("desc_fields", {desc_src, desc_dst, desc_len, desc_ctrl}, {e.src, e.dst, e.len, e.ctrl});
          pend_done = dpq.pop_front();
          dcnt = 3;
        end
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          done_valid = 1'b1;
          {done_status, done_bytes} = pend_done;
        end
      end
      if (done_cnt > 0) post++;
    end
    m_waitrequest = 1'b0;
    if (post < 4) fail("timeout_chain_done");
    chk("done_pulses", done_cnt, 1);
    chk("reads_left", rq.size(), 0);
    chk("descs_left", dq.size(), 0);
    chk("wbs_left", wq.size(), 0);
  endtask

  initial begin
    tbl[0] = '{12'h000, 32'h1000_0000, 32'h2000_0000, 32'h0000_0020, 32'h0000_05EE, 32'h8000_0000, 16'h05EE, 8'h00, 32'h0000_05EE, 1'b0};
    tbl[1] = '{12'h020, 32'hAAAA_0000, 32'hBBBB_0000, 32'h0, 32'h0000_0040, 32'h0000_0000, 16'h0, 8'h0, 32'h0, 1'b0};
    tbl[2] = '{12'h000, 32'h1111_1111, 32'h2222_2222, 32'h0000_0045, 32'hABCD_0100, 32'hC300_0000, 16'h0100, 8'h5A, 32'h435A_0100, 1'b0};
    tbl[3] = '{12'h040, 32'h3333_3333, 32'h4444_4444, 32'h1234_5100, 32'h0000_0040, 32'h8100_0000, 16'h003C, 8'h81, 32'h0181_003C, 1'b0};
    tbl[4] = '{12'h100, 32'h5555_5555, 32'h6666_6666, 32'h0000_0200, 32'h0000_FFFF, 32'hFF12_3456, 16'hFFFF, 8'hFF, 32'h7FFF_FFFF, 1'b0};
    tbl[5] = '{12'h200, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF, 16'h0, 8'h0, 32'h0, 1'b0};
    tbl[6] = '{12'h300, 32'h9, 32'h9, 32'h0, 32'h9, 32'h7F00_0000, 16'h0, 8'h0, 32'h0, 1'b0};
    tbl[7] = '{12'h3E0, 32'hCAFE_0000, 32'hBEEF_0000, 32'h0000_03E0, 32'h0000_0200, 32'h8500_0000, 16'h0200, 8'h11, 32'h0511_0200, 1'b0};
    tbl[8] = '{12'h3E0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0, 8'h0, 32'h0, 1'b1};
    reset_n = 1'b0; start = 1'b0; first_desc_addr = 12'h0; m_waitrequest = 1'b0;
    m_readdata = 32'h0; m_readdatavalid = 1'b0; desc_ready = 1'b1;
    done_valid = 1'b0; done_bytes = 16'h0; done_status = 8'h0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset_n = 1'b1;
    run_chain(0, 1, 1'b0, 0, 17, -1, 1'b0);
    run_chain(2, 5, 1'b0, 0, 17, -1, 1'b0);
    run_chain(2, 5, 1'b1, 0, -1, -1, 1'b0);
    run_chain(6, 6, 1'b0, 0, -1, 17, 1'b0);
    run_chain(0, 1, 1'b0, 20, 17, -1, 1'b0);
    run_chain(7, 8, 1'b0, 0, 17, -1, 1'b0);
    run_chain(0, 1, 1'b0, 0, -1, -1, 1'b1);
    @(negedge clk);
    chk_reset("held_rst");
    reset_n = 1'b1;
    m_waitrequest = 1'b0;
    rq.delete(); dq.delete(); wq.delete(); dpq.delete();
    run_chain(0, 1, 1'b0, 0, 17, -1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
